regfile_write_port: RTL and testbench

//   Register-file write-back port, the write-side counterpart of the 32:1 read mux.
//   - Accepts write requests (addr, data) over a valid/ready handshake.
//   - Buffers them in a small FIFO.
//   - Decodes the FIFO head address into a registered one-hot write-enable vector driving the per-register enables.
//   - Holds writes while the register file signals stall; discards writes to register 0.

---
 rtl/regfile_write_port.sv | 165 ++++++++++++++++
 tb/tb_regfile_write_port.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_port.sv
// regfile_write_port
//   Write-back port for a register file. Write requests (address, data) are
//   accepted over a valid/ready handshake and queued in a small FIFO. The FIFO
//   head is committed whenever the register file is not stalling. A commit
//   produces a registered, single-cycle one-hot write enable plus the matching
//   data. Writes to register 0 are dropped, and a saturating counter tracks
//   how many were dropped.
//
// Optional feature: define WB_FORWARD_EN to add two combinational read-forward
//   lookups over the queued writes and the committing output stage.
//
// Parameters: DEPTH (FIFO entries, power of two 2..8), ADDR_W, DATA_W.
// Ports:
//   clock, reset_n  rising-edge clock, asynchronous active-low reset
//   wr_valid/wr_ready/wr_addr/wr_data  write request handshake
//   rf_stall        register file busy; no commit while high
//   we_onehot       one-hot write enable pulse (bit i writes reg i)
//   we_data         data for the current we_onehot pulse
//   pending         FIFO occupancy
//   drop_cnt        saturating count of discarded register-0 writes
//   (WB_FORWARD_EN) rd_addr_a/b in; fwd_hit_a/b, fwd_data_a/b out
//
// Handshake: a request transfers at a rising edge where wr_valid and wr_ready
//   are both high. wr_ready is registered and never depends on wr_valid.
//   A full FIFO that pops on an edge does not accept a new request on that
//   same edge.
module regfile_write_port #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   rf_stall,
  output logic [(2**ADDR_W)-1:0] we_onehot,
  output logic [DATA_W-1:0]      we_data,
  output logic [3:0]             pending,
  output logic [7:0]             drop_cnt
`ifdef WB_FORWARD_EN
  ,
  input  logic [ADDR_W-1:0]      rd_addr_a,
  input  logic [ADDR_W-1:0]      rd_addr_b,
  output logic                   fwd_hit_a,
  output logic                   fwd_hit_b,
  output logic [DATA_W-1:0]      fwd_data_a,
  output logic [DATA_W-1:0]      fwd_data_b
`endif
);

  localparam int NREG  = 2**ADDR_W;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] DEPTH_C = 4'(DEPTH);

  logic [ADDR_W-1:0] mem_addr_q [DEPTH];
  logic [DATA_W-1:0] mem_data_q [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [3:0]        count_q, count_d;
  logic              wr_ready_q, wr_ready_d;
  logic [NREG-1:0]   we_onehot_q, we_onehot_d;
  logic [DATA_W-1:0] we_data_q, we_data_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;

  logic              push, pop;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;

  assign push      = wr_valid & wr_ready_q;
  assign pop       = (count_q != 4'd0) & ~rf_stall;
  assign head_addr = mem_addr_q[rd_ptr_q];
  assign head_data = mem_data_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    we_onehot_d = '0;
    we_data_d   = we_data_q;
    drop_cnt_d  = drop_cnt_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    // Occupancy comes from this counter alone; equal pointers are ambiguous.
    if (push && !pop)      count_d = count_q + 4'd1;
    else if (pop && !push) count_d = count_q - 4'd1;

    if (pop) begin
      we_data_d = head_data;
      if (head_addr != '0) begin
        we_onehot_d = {{(NREG-1){1'b0}}, 1'b1} << head_addr;
      end else if (drop_cnt_q != 8'hFF) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end

    // Ready looks at the post-edge count, so a full FIFO that pops reopens
    // one cycle later rather than refilling on the same edge.
    wr_ready_d = (count_d != DEPTH_C);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wr_ready_q  <= 1'b0;
      we_onehot_q <= '0;
      we_data_q   <= '0;
      drop_cnt_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wr_ready_q  <= wr_ready_d;
      we_onehot_q <= we_onehot_d;
      we_data_q   <= we_data_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // Storage needs no reset: only entries covered by count_q are ever read.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_addr_q[wr_ptr_q] <= wr_addr;
      mem_data_q[wr_ptr_q] <= wr_data;
    end
  end

  assign wr_ready  = wr_ready_q;
  assign we_onehot = we_onehot_q;
  assign we_data   = we_data_q;
  assign pending   = count_q;
  assign drop_cnt  = drop_cnt_q;

`ifdef WB_FORWARD_EN
  // The result is {hit, data}. The search runs from oldest to youngest, so
  // the youngest match wins. The committing output stage is older than every
  // entry still in the FIFO.
  function automatic logic [DATA_W:0] fwd_lookup(input logic [ADDR_W-1:0] ra);
    logic [DATA_W:0]  res;
    logic [PTR_W-1:0] idx;
    res = '0;
    if (ra != '0) begin
      if (we_onehot_q[ra]) res = {1'b1, we_data_q};
      for (int i = 0; i < DEPTH; i++) begin
        idx = rd_ptr_q + PTR_W'(i);
        if ((4'(i) < count_q) && (mem_addr_q[idx] == ra)) res = {1'b1, mem_data_q[idx]};
      end
    end
    return res;
  endfunction

  always_comb begin
    {fwd_hit_a, fwd_data_a} = fwd_lookup(rd_addr_a);
    {fwd_hit_b, fwd_data_b} = fwd_lookup(rd_addr_b);
  end
`endif

endmodule

// File: tb/tb_regfile_write_port.sv
module tb_regfile_write_port;
  localparam int DEPTH  = 2;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int NREG   = 32;
  localparam int EW     = ADDR_W + DATA_W;

  logic              clock    = 1'b0;
  logic              reset_n  = 1'b0;
  logic              wr_valid = 1'b0;
  logic [ADDR_W-1:0] wr_addr  = '0;
  logic [DATA_W-1:0] wr_data  = '0;
  logic              rf_stall = 1'b0;
  logic              wr_ready;
  logic [NREG-1:0]   we_onehot;
  logic [DATA_W-1:0] we_data;
  logic [3:0]        pending;
  logic [7:0]        drop_cnt;
`ifdef WB_FORWARD_EN
  logic [ADDR_W-1:0] rd_addr_a = '0;
  logic [ADDR_W-1:0] rd_addr_b = '0;
  logic              fwd_hit_a, fwd_hit_b;
  logic [DATA_W-1:0] fwd_data_a, fwd_data_b;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  regfile_write_port #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rf_stall  (rf_stall),
    .we_onehot (we_onehot),
    .we_data   (we_data),
    .pending   (pending),
    .drop_cnt  (drop_cnt)
`ifdef WB_FORWARD_EN
    ,
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .fwd_hit_a (fwd_hit_a),
    .fwd_hit_b (fwd_hit_b),
    .fwd_data_a(fwd_data_a),
    .fwd_data_b(fwd_data_b)
`endif
  );

  // ---------------- clock ----------------
  initial forever #5 clock = ~clock;

  // ---------------- checker ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Queue of {addr, data} waiting to commit, plus the outputs that the spec
  // says must be visible after each edge.
  logic [EW-1:0]     exp_q[$];
  logic [NREG-1:0]   exp_onehot = '0;
  logic [DATA_W-1:0] exp_data   = '0;
  int                exp_drop   = 0;
  logic              exp_ready  = 1'b0;

  initial forever begin
    @(posedge clock or negedge reset_n);
    if (!reset_n) begin
      exp_q.delete();
      exp_onehot = '0;
      exp_data   = '0;
      exp_drop   = 0;
      exp_ready  = 1'b0;
    end else begin
      bit            do_push, do_pop;
      logic [EW-1:0] h;
      do_push    = wr_valid && exp_ready;
      do_pop     = (exp_q.size() > 0) && !rf_stall;
      exp_onehot = '0;
      if (do_pop) begin
        h        = exp_q.pop_front();
        exp_data = h[DATA_W-1:0];
        if (h[EW-1:DATA_W] == 0) begin
          if (exp_drop < 255) exp_drop++;
        end else begin
          exp_onehot[h[EW-1:DATA_W]] = 1'b1;
        end
      end
      if (do_push) exp_q.push_back({wr_addr, wr_data});
      exp_ready = (exp_q.size() < DEPTH);
    end
  end

  // Every cycle, compare the DUT against the model, sampling at the falling edge.
  initial forever begin
    @(negedge clock);
    check("pending",   64'(pending),   64'(exp_q.size()));
    check("wr_ready",  64'(wr_ready),  64'(exp_ready));
    check("we_onehot", 64'(we_onehot), 64'(exp_onehot));
    check("drop_cnt",  64'(drop_cnt),  64'(exp_drop));
    if (exp_onehot != '0) check("we_data", 64'(we_data), 64'(exp_data));
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_one(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int stall_pct;

    repeat (2) tick();
    reset_n = 1'b1;
    check("ready_before_first_edge", 64'(wr_ready), 64'd0);
    tick();
    check("ready_after_release", 64'(wr_ready), 64'd1);
    check("pending_after_release", 64'(pending), 64'd0);

    // Single write: the pulse appears one edge after the accept edge.
    push_one(5'd5, 32'hDEAD_BEEF);
    check("t1_pending_after_push", 64'(pending), 64'd1);
    check("t1_no_early_enable", 64'(we_onehot), 64'd0);
    tick();
    check("t1_onehot", 64'(we_onehot), 64'h0000_0020);
    check("t1_data", 64'(we_data), 64'hDEAD_BEEF);
    tick();
    check("t1_pulse_one_cycle", 64'(we_onehot), 64'd0);

    // Fill while stalled, try a refused third push, then drain in order.
    rf_stall = 1'b1;
    push_one(5'd3, 32'h3333_3333);
    push_one(5'd4, 32'h4444_4444);
    check("t2_pending_full", 64'(pending), 64'd2);
    check("t2_ready_low", 64'(wr_ready), 64'd0);
    wr_valid = 1'b1;
    wr_addr  = 5'd9;
    wr_data  = 32'h9999_9999;
    repeat (2) tick();
    check("t2_third_refused", 64'(pending), 64'd2);
    wr_valid = 1'b0;
    rf_stall = 1'b0;
    tick();
    check("t2_first_commit", 64'(we_onehot), 64'h8);
    tick();
    check("t2_second_commit", 64'(we_onehot), 64'h10);
    check("t2_drained", 64'(pending), 64'd0);
    tick();

    // Writes to register 0 are dropped and counted (saturating).
    push_one(5'd0, 32'h1234);
    tick();
    check("t3_drop_one", 64'(drop_cnt), 64'd1);
    check("t3_no_enable", 64'(we_onehot), 64'd0);
    check("t3_pending_zero", 64'(pending), 64'd0);
    wr_valid = 1'b1;
    wr_addr  = 5'd0;
    repeat (299) tick();
    wr_valid = 1'b0;
    repeat (2) tick();
    check("t3_drop_saturated", 64'(drop_cnt), 64'd255);

    // Back-to-back writes to registers 1..31: one pulse per cycle, in order.
    for (int a = 1; a < 32; a++) begin
      wr_valid = 1'b1;
      wr_addr  = ADDR_W'(a);
      wr_data  = $urandom;
      tick();
      if (a > 1) begin
        check("t4_pulse_order", 64'(we_onehot), 64'(32'd1 << (a - 1)));
        check("t4_pending_one", 64'(pending), 64'd1);
      end
    end
    wr_valid = 1'b0;
    tick();
    check("t4_last_pulse", 64'(we_onehot), 64'h8000_0000);
    tick();

    // Asynchronous reset while two writes are held by a stall.
    rf_stall = 1'b1;
    push_one(5'd10, 32'hAAAA_0010);
    push_one(5'd11, 32'hAAAA_0011);
    check("t5_pending_before_reset", 64'(pending), 64'd2);
    reset_n = 1'b0;
    #1;
    check("t5_async_onehot", 64'(we_onehot), 64'd0);
    check("t5_async_data", 64'(we_data), 64'd0);
    check("t5_async_pending", 64'(pending), 64'd0);
    check("t5_async_drop", 64'(drop_cnt), 64'd0);
    check("t5_async_ready", 64'(wr_ready), 64'd0);
    tick();
    reset_n  = 1'b1;
    rf_stall = 1'b0;
    repeat (5) begin
      tick();
      check("t5_no_stale_write", 64'(we_onehot), 64'd0);
    end

`ifdef WB_FORWARD_EN
    // Forwarding returns the youngest pending write to the same register.
    rf_stall = 1'b1;
    push_one(5'd7, 32'h11);
    push_one(5'd7, 32'h22);
    rd_addr_a = 5'd7;
    rd_addr_b = 5'd0;
    #1;
    check("t6_hit_a", 64'(fwd_hit_a), 64'd1);
    check("t6_data_a", 64'(fwd_data_a), 64'h22);
    check("t6_hit_b", 64'(fwd_hit_b), 64'd0);
    check("t6_data_b", 64'(fwd_data_b), 64'd0);
    rf_stall  = 1'b0;
    rd_addr_a = 5'd0;
    repeat (3) tick();
`endif

    // Randomized traffic with varying stall pressure, checked by the model.
    for (int phase = 0; phase < 6; phase++) begin
      stall_pct = (phase % 3) * 35;
      for (int c = 0; c < 500; c++) begin
        wr_valid = ($urandom_range(0, 3) != 0);
        wr_addr  = ($urandom_range(0, 7) == 0) ? '0 : ADDR_W'($urandom_range(0, NREG - 1));
        wr_data  = $urandom;
        rf_stall = ($urandom_range(0, 99) < stall_pct);
        tick();
      end
    end
    wr_valid = 1'b0;
    rf_stall = 1'b0;
    repeat (6) tick();
    check("final_drained", 64'(pending), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
